wb_stage: RTL
=============

Name: wb_stage

Overview:
- Final (write-back) stage of the five-stage LoongArch pipeline; consumes the registered MEM→WB bundle.
- Commits register-file writes and CSR writes, and arbitrates exceptions and ERTN.
- Raises the pipeline flush with its redirect target.
- Owns the exception-related CSRs and publishes the interrupt-pending flag and a CSR read port to earlier stages.

Parameters:
- RESET_PC, 32'h1c000000, value of debug_wb_pc while no valid instruction is in WB.
- EENTRY_RST, 32'h0, reset value of EENTRY.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ms_ready_go  in  1  MEM stage has a result ready to pass
- ms_valid  in  1  MEM stage holds a valid instruction
- ws_allow_in  out  1  WB can accept; constant 1
- ws_valid  out  1  WB holds a valid instruction
- wb_pc  in  32  PC of the WB instruction
- wb_rf_we  in  4  byte write enables for the GPR
- wb_rf_waddr  in  5  destination GPR
- wb_rf_wdata  in  32  GPR write data
- wb_sram_addr  in  32  memory vaddr, used for BADV on ALE
- wb_csr_we  in  4  any nonzero value means CSR write
- wb_csr_num  in  14  CSR number
- wb_csr_wdata  in  32  CSR write data
- wb_csr_wmask  in  32  CSR write bit mask
- wb_ertn  in  1  ERTN instruction
- wb_excp_syscall, wb_excp_break, wb_excp_ale, wb_excp_ine, wb_excp_ipe, wb_excp_adef, wb_has_int  in  1 each  exception tags
- hw_int  in  8  external hardware interrupt lines
- csr_rnum  in  14  CSR read number from the EX stage
- csr_rvalue  out  32  combinational CSR read data
- has_int  out  1  interrupt pending and enabled
- rf_we  out  4  committed GPR byte enables
- rf_waddr  out  5  committed GPR number
- rf_wdata  out  32  committed GPR data
- flush  out  1  pipeline flush, combinational
- flush_target  out  32  redirect PC
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_we  out  4  trace GPR write enables
- debug_wb_rf_wnum  out  5  trace GPR number
- debug_wb_rf_wdata  out  32  trace GPR data

Behaviour:
- ws_valid update at posedge, in priority order:
  - reset or flush → 0.
  - else if ms_ready_go & ws_allow_in → ms_valid.
- Reset values: ws_valid=0; CRMD=32'h8 (DA=1, PLV=0, IE=0); EENTRY=EENTRY_RST; every other CSR 0.
- wb_ex = ws_valid & (syscall|break|ale|ine|ipe|adef|has_int).
- wb_ertn = ws_valid & wb_ertn & ~wb_ex.
- flush = wb_ex | wb_ertn, asserted in the same cycle. flush_target = wb_ex ? EENTRY : ERA.
- rf_we = (ws_valid & ~wb_ex) ? wb_rf_we : 0. rf_waddr and rf_wdata pass through unchanged.
- Debug outputs mirror rf_*. debug_wb_pc = ws_valid ? wb_pc : RESET_PC.
- Exception priority, Ecode and EsubCode:
  - INT: 0x0
  - ADEF: 0x8, sub 0
  - SYS: 0xB
  - BRK: 0xC
  - INE: 0xD
  - IPE: 0xE
  - ALE: 0x9, lowest priority
- On wb_ex at posedge:
  - PRMD.PPLV←CRMD.PLV and PRMD.PIE←CRMD.IE.
  - CRMD.PLV←0 and CRMD.IE←0.
  - ERA←wb_pc.
  - ESTAT[21:16]←Ecode and ESTAT[30:22]←EsubCode.
  - BADV←wb_pc for ADEF, wb_sram_addr for ALE, unchanged otherwise.
- On wb_ertn at posedge: CRMD.PLV←PRMD.PPLV and CRMD.IE←PRMD.PIE.
- CSR write:
  - Enabled when ws_valid & ~wb_ex & (wb_csr_we≠0).
  - new = (old & ~m) | (wdata & m), where m = wb_csr_wmask & the register's writable mask.
- Writable masks:
  - CRMD 0x1FF
  - PRMD 0x7
  - ECFG 0x1BFF
  - ESTAT 0x3, software IS only
  - ERA, BADV, SAVE0-3: all bits
  - EENTRY 0xFFFFFFC0
- ESTAT[9:2] ← hw_int every cycle, independent of writes. ESTAT[11] tied 0.
- CSR numbers: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33. Unimplemented numbers read 0; writes to them are ignored.
- csr_rvalue is a combinational read of the current register state; it does not bypass a write in the same cycle.
- has_int = CRMD.IE & |(ESTAT[12:0] & ECFG[12:0]).
- Simultaneous events:
  - Exception plus CSR write on the same instruction: the exception wins and the write is dropped.
  - Exception plus ERTN: the exception wins.
  - Reset together with an exception: reset wins.
- flush is never asserted while ws_valid=0.

Decomposition:
- Shared package holds:
  - CSR number constants
  - Ecode and EsubCode constants
  - writable-mask constants
  - CRMD reset value
- Sub-module csr_file holds the CSR registers, the masked-write logic, exception/ERTN side effects and the read mux.
- wb_stage keeps valid tracking, exception arbitration, flush and the GPR commit.

Test Plan:
- Reset, then idle → ws_valid=0, debug_wb_pc=32'h1c000000, CRMD=0x8, flush=0.
- Valid ADD with rf_we=4'hF, waddr=5, wdata=0x1234 → rf_we=4'hF, rf_waddr=5, rf_wdata=0x1234 for one cycle, flush=0.
- Valid SYSCALL at pc=0x1c000100 with EENTRY=0x1c008000 and CRMD=0x7:
  - Same cycle: flush=1, flush_target=0x1c008000, rf_we=0.
  - Next cycle: ERA=0x1c000100, ESTAT[21:16]=0xB, PRMD=0x7, CRMD.PLV=0, CRMD.IE=0, ws_valid=0.
- ALE at vaddr 0x80000003 carrying a CSR write to SAVE0 → BADV=0x80000003, Ecode=0x9, SAVE0 unchanged.
- csrxchg to CRMD with wdata=0x4, mask=0x4 → IE=1.
  - Then hw_int[0]=1 with ECFG=0x4 → has_int=1.
  - The next valid instruction carrying has_int → Ecode=0x0, flush=1.
- ERTN with ERA=0x1c000200 and PRMD=0x7 → flush=1, flush_target=0x1c000200; next cycle CRMD.PLV=3, CRMD.IE=1.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: CSR numbers, exception codes,
// writable masks and reset values.
package wb_stage_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h0000;
  localparam logic [13:0] CSR_PRMD   = 14'h0001;
  localparam logic [13:0] CSR_ECFG   = 14'h0004;
  localparam logic [13:0] CSR_ESTAT  = 14'h0005;
  localparam logic [13:0] CSR_ERA    = 14'h0006;
  localparam logic [13:0] CSR_BADV   = 14'h0007;
  localparam logic [13:0] CSR_EENTRY = 14'h000C;
  localparam logic [13:0] CSR_SAVE0  = 14'h0030;
  localparam logic [13:0] CSR_SAVE1  = 14'h0031;
  localparam logic [13:0] CSR_SAVE2  = 14'h0032;
  localparam logic [13:0] CSR_SAVE3  = 14'h0033;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;
  localparam logic [5:0] ECODE_IPE = 6'h0E;

  localparam logic [8:0] ESUBCODE_NONE = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

  localparam logic [31:0] WMASK_CRMD   = 32'h0000_01FF;
  localparam logic [31:0] WMASK_PRMD   = 32'h0000_0007;
  localparam logic [31:0] WMASK_ECFG   = 32'h0000_1BFF;
  localparam logic [31:0] WMASK_ESTAT  = 32'h0000_0003;
  localparam logic [31:0] WMASK_ALL    = 32'hFFFF_FFFF;
  localparam logic [31:0] WMASK_EENTRY = 32'hFFFF_FFC0;

  localparam logic [31:0] CRMD_RST = 32'h0000_0008;

  function automatic logic [31:0] masked_write(input logic [31:0] old_v,
                                               input logic [31:0] wdata,
                                               input logic [31:0] mask);
    return (old_v & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/wb_stage_csr_file.sv
// Exception-related CSRs: masked software writes, exception/ERTN side effects,
// hardware interrupt sampling and the combinational read port.
module wb_stage_csr_file
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EENTRY_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ex,
  input  logic        i_ertn,
  input  logic [5:0]  i_ecode,
  input  logic [8:0]  i_esubcode,
  input  logic [31:0] i_ex_pc,
  input  logic        i_badv_we,
  input  logic [31:0] i_badv,
  input  logic        i_we,
  input  logic [13:0] i_wnum,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_wmask,
  input  logic [7:0]  i_hw_int,
  input  logic [13:0] i_rnum,
  output logic [31:0] o_rvalue,
  output logic [31:0] o_eentry,
  output logic [31:0] o_era,
  output logic        o_has_int
);

  logic [31:0] r_crmd, r_prmd, r_ecfg, r_estat, r_era, r_badv, r_eentry;
  logic [31:0] r_save0, r_save1, r_save2, r_save3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crmd   <= CRMD_RST;
      r_prmd   <= '0;
      r_ecfg   <= '0;
      r_estat  <= '0;
      r_era    <= '0;
      r_badv   <= '0;
      r_eentry <= EENTRY_RST;
      r_save0  <= '0;
      r_save1  <= '0;
      r_save2  <= '0;
      r_save3  <= '0;
    end else begin
      if (i_ex) begin
        r_prmd[2:0]    <= r_crmd[2:0];
        r_crmd[2:0]    <= 3'b000;
        r_era          <= i_ex_pc;
        r_estat[21:16] <= i_ecode;
        r_estat[30:22] <= i_esubcode;
        if (i_badv_we) r_badv <= i_badv;
      end else if (i_ertn) begin
        r_crmd[2:0] <= r_prmd[2:0];
      end
      if (i_we) begin
        case (i_wnum)
          CSR_CRMD:   r_crmd   <= masked_write(r_crmd,   i_wdata, i_wmask & WMASK_CRMD);
          CSR_PRMD:   r_prmd   <= masked_write(r_prmd,   i_wdata, i_wmask & WMASK_PRMD);
          CSR_ECFG:   r_ecfg   <= masked_write(r_ecfg,   i_wdata, i_wmask & WMASK_ECFG);
          CSR_ESTAT:  r_estat  <= masked_write(r_estat,  i_wdata, i_wmask & WMASK_ESTAT);
          CSR_ERA:    r_era    <= masked_write(r_era,    i_wdata, i_wmask & WMASK_ALL);
          CSR_BADV:   r_badv   <= masked_write(r_badv,   i_wdata, i_wmask & WMASK_ALL);
          CSR_EENTRY: r_eentry <= masked_write(r_eentry, i_wdata, i_wmask & WMASK_EENTRY);
          CSR_SAVE0:  r_save0  <= masked_write(r_save0,  i_wdata, i_wmask & WMASK_ALL);
          CSR_SAVE1:  r_save1  <= masked_write(r_save1,  i_wdata, i_wmask & WMASK_ALL);
          CSR_SAVE2:  r_save2  <= masked_write(r_save2,  i_wdata, i_wmask & WMASK_ALL);
          CSR_SAVE3:  r_save3  <= masked_write(r_save3,  i_wdata, i_wmask & WMASK_ALL);
          default: ;
        endcase
      end
      // Placed last so the hardware lines always override the ESTAT write above.
      r_estat[9:2] <= i_hw_int;
    end
  end

  always_comb begin
    o_rvalue = '0;
    case (i_rnum)
      CSR_CRMD:   o_rvalue = r_crmd;
      CSR_PRMD:   o_rvalue = r_prmd;
      CSR_ECFG:   o_rvalue = r_ecfg;
      CSR_ESTAT:  o_rvalue = r_estat;
      CSR_ERA:    o_rvalue = r_era;
      CSR_BADV:   o_rvalue = r_badv;
      CSR_EENTRY: o_rvalue = r_eentry;
      CSR_SAVE0:  o_rvalue = r_save0;
      CSR_SAVE1:  o_rvalue = r_save1;
      CSR_SAVE2:  o_rvalue = r_save2;
      CSR_SAVE3:  o_rvalue = r_save3;
      default:    o_rvalue = '0;
    endcase
  end

  assign o_eentry  = r_eentry;
  assign o_era     = r_era;
  assign o_has_int = r_crmd[2] & (|(r_estat[12:0] & r_ecfg[12:0]));

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: valid tracking, exception/ERTN arbitration, pipeline flush
// and GPR commit; CSR state lives in wb_stage_csr_file.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter logic [31:0] EENTRY_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_ready_go,
  input  logic        ms_valid,
  output logic        ws_allow_in,
  output logic        ws_valid,
  input  logic [31:0] wb_pc,
  input  logic [3:0]  wb_rf_we,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [31:0] wb_rf_wdata,
  input  logic [31:0] wb_sram_addr,
  input  logic [3:0]  wb_csr_we,
  input  logic [13:0] wb_csr_num,
  input  logic [31:0] wb_csr_wdata,
  input  logic [31:0] wb_csr_wmask,
  input  logic        wb_ertn,
  input  logic        wb_excp_syscall,
  input  logic        wb_excp_break,
  input  logic        wb_excp_ale,
  input  logic        wb_excp_ine,
  input  logic        wb_excp_ipe,
  input  logic        wb_excp_adef,
  input  logic        wb_has_int,
  input  logic [7:0]  hw_int,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  output logic        has_int,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        r_ws_valid;
  logic        w_ex;
  logic        w_ertn;
  logic [5:0]  w_ecode;
  logic [8:0]  w_esubcode;
  logic        w_badv_we;
  logic [31:0] w_badv;
  logic        w_csr_we;
  logic [31:0] w_eentry;
  logic [31:0] w_era;

  assign ws_allow_in = 1'b1;
  assign ws_valid    = r_ws_valid;

  assign w_ex = r_ws_valid & (wb_excp_syscall | wb_excp_break | wb_excp_ale | wb_excp_ine |
                              wb_excp_ipe | wb_excp_adef | wb_has_int);
  assign w_ertn       = r_ws_valid & wb_ertn & ~w_ex;
  assign flush        = w_ex | w_ertn;
  assign flush_target = w_ex ? w_eentry : w_era;

  always_ff @(posedge clk) begin
    if (reset || flush) r_ws_valid <= 1'b0;
    else if (ms_ready_go && ws_allow_in) r_ws_valid <= ms_valid;
  end

  // Fixed-priority cause select; ALE is the fall-through lowest priority.
  always_comb begin
    w_ecode    = ECODE_ALE;
    w_esubcode = ESUBCODE_NONE;
    w_badv_we  = 1'b0;
    w_badv     = wb_sram_addr;
    if (wb_has_int) begin
      w_ecode = ECODE_INT;
    end else if (wb_excp_adef) begin
      w_ecode    = ECODE_ADE;
      w_esubcode = ESUBCODE_ADEF;
      w_badv_we  = 1'b1;
      w_badv     = wb_pc;
    end else if (wb_excp_syscall) begin
      w_ecode = ECODE_SYS;
    end else if (wb_excp_break) begin
      w_ecode = ECODE_BRK;
    end else if (wb_excp_ine) begin
      w_ecode = ECODE_INE;
    end else if (wb_excp_ipe) begin
      w_ecode = ECODE_IPE;
    end else if (wb_excp_ale) begin
      w_badv_we = 1'b1;
    end
  end

  assign w_csr_we = r_ws_valid & ~w_ex & (|wb_csr_we);

  wb_stage_csr_file #(.EENTRY_RST(EENTRY_RST)) u_csr_file (
    .clk        (clk),
    .reset      (reset),
    .i_ex       (w_ex),
    .i_ertn     (w_ertn),
    .i_ecode    (w_ecode),
    .i_esubcode (w_esubcode),
    .i_ex_pc    (wb_pc),
    .i_badv_we  (w_badv_we),
    .i_badv     (w_badv),
    .i_we       (w_csr_we),
    .i_wnum     (wb_csr_num),
    .i_wdata    (wb_csr_wdata),
    .i_wmask    (wb_csr_wmask),
    .i_hw_int   (hw_int),
    .i_rnum     (csr_rnum),
    .o_rvalue   (csr_rvalue),
    .o_eentry   (w_eentry),
    .o_era      (w_era),
    .o_has_int  (has_int)
  );

  assign rf_we    = (r_ws_valid && !w_ex) ? wb_rf_we : 4'h0;
  assign rf_waddr = wb_rf_waddr;
  assign rf_wdata = wb_rf_wdata;

  assign debug_wb_pc       = r_ws_valid ? wb_pc : RESET_PC;
  assign debug_wb_rf_we    = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule
